// File: rtl/arc4_gen_if.sv
// rtl/arc4_gen_if.sv - start handshake and memory-port bundle for the arc4_gen core
`timescale 1ns/1ps
interface arc4_gen_if #(
    parameter int KEY_BYTES = 3
);
    logic                   en;
    logic                   rdy;
    logic [KEY_BYTES*8-1:0] key;
    logic [7:0]             ct_addr;
    logic [7:0]             ct_rddata;
    logic [7:0]             pt_addr;
    logic [7:0]             pt_rddata;
    logic [7:0]             pt_wrdata;
    logic                   pt_wren;
    logic [7:0]             s_addr;
    logic [7:0]             s_rddata;
    logic [7:0]             s_wrdata;
    logic                   s_wren;

    // Environment side: requests jobs and owns the memories
    modport master (
        output en, key, ct_rddata, pt_rddata, s_rddata,
        input  rdy, ct_addr, pt_addr, pt_wrdata, pt_wren, s_addr, s_wrdata, s_wren
    );

    // Core side
    modport slave (
        input  en, key, ct_rddata, pt_rddata, s_rddata,
        output rdy, ct_addr, pt_addr, pt_wrdata, pt_wren, s_addr, s_wrdata, s_wren
    );
endinterface

// File: rtl/arc4_gen.sv
// rtl/arc4_gen.sv - parametrised ARC4 decryption core with key length and dropN keystream discard
`timescale 1ns/1ps
module arc4_gen #(
    parameter int KEY_BYTES = 3,
    parameter int DROP_N    = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    arc4_gen_if.slave   bus
);
    localparam int         KW        = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [9:0] DROP_LAST = 10'((DROP_N > 0) ? DROP_N - 1 : 0);

    // KSA_* walk the key schedule; KS_* is one keystream step shared by the
    // discard phase (prga=0) and the message phase (prga=1).
    typedef enum logic [4:0] {
        IDLE,
        INIT,
        KSA_RI, KSA_WI, KSA_RJ, KSA_WJ, KSA_SJ,
        KS_RI, KS_WI, KS_RJ, KS_WJ, KS_SJ, KS_RK, KS_KS,
        LEN_RD, LEN_WR
    } state_t;

    state_t                 state, state_nx;
    logic [KEY_BYTES*8-1:0] key_reg;
    logic [7:0]             i, j, si, sj, len;
    logic [8:0]             k;
    logic [KW-1:0]          kidx;
    logic [9:0]             drop_cnt;
    logic                   prga;
    logic [7:0]             key_byte;

    logic                   rdy;
    logic [7:0]             s_addr, s_wrdata, ct_addr, pt_addr, pt_wrdata;
    logic                   s_wren, pt_wren;

    logic last_i, drop_last, k_last;
    assign last_i    = (i == 8'hFF);
    assign drop_last = (drop_cnt == DROP_LAST);
    assign k_last    = (k == {1'b0, len});

    // The plaintext read port exists only for symmetry with the other memories
    logic unused_pt_rddata;
    assign unused_pt_rddata = ^bus.pt_rddata;

    // Select the current key byte, MSB-first, without a divider
    always_comb begin
        key_byte = '0;
        for (int b = 0; b < KEY_BYTES; b++) begin
            if (kidx == KW'(b)) key_byte = key_reg[KEY_BYTES*8-1-8*b -: 8];
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state and memory-port decode; ports are quiet unless a state drives them
    always_comb begin
        state_nx  = state;
        rdy       = 1'b0;
        s_addr    = 8'd0;
        s_wrdata  = 8'd0;
        s_wren    = 1'b0;
        ct_addr   = 8'd0;
        pt_addr   = 8'd0;
        pt_wrdata = 8'd0;
        pt_wren   = 1'b0;
        case (state)
            IDLE: begin
                rdy = 1'b1;
                if (bus.en) state_nx = INIT;
            end
            INIT: begin
                s_addr   = i;
                s_wrdata = i;
                s_wren   = 1'b1;
                if (last_i) state_nx = KSA_RI;
            end
            KSA_RI: begin
                s_addr   = i;
                state_nx = KSA_WI;
            end
            KSA_WI: state_nx = KSA_RJ;
            KSA_RJ: begin
                s_addr   = j;
                state_nx = KSA_WJ;
            end
            // s[j] arrives this cycle and goes straight into s[i]
            KSA_WJ: begin
                s_addr   = i;
                s_wrdata = bus.s_rddata;
                s_wren   = 1'b1;
                state_nx = KSA_SJ;
            end
            KSA_SJ: begin
                s_addr   = j;
                s_wrdata = si;
                s_wren   = 1'b1;
                if (!last_i)         state_nx = KSA_RI;
                else if (DROP_N == 0) state_nx = LEN_RD;
                else                 state_nx = KS_RI;
            end
            KS_RI: begin
                s_addr   = i + 8'd1;
                state_nx = KS_WI;
            end
            KS_WI: state_nx = KS_RJ;
            KS_RJ: begin
                s_addr   = j;
                state_nx = KS_WJ;
            end
            KS_WJ: begin
                s_addr   = i;
                s_wrdata = bus.s_rddata;
                s_wren   = 1'b1;
                state_nx = KS_SJ;
            end
            KS_SJ: begin
                s_addr   = j;
                s_wrdata = si;
                s_wren   = 1'b1;
                state_nx = KS_RK;
            end
            // Post-swap s[i]+s[j] equals pre-swap si+sj; ciphertext read overlaps
            KS_RK: begin
                s_addr   = si + sj;
                ct_addr  = k[7:0];
                state_nx = KS_KS;
            end
            KS_KS: begin
                if (prga) begin
                    pt_addr   = k[7:0];
                    pt_wrdata = bus.ct_rddata ^ bus.s_rddata;
                    pt_wren   = 1'b1;
                    state_nx  = k_last ? IDLE : KS_RI;
                end else begin
                    state_nx  = drop_last ? LEN_RD : KS_RI;
                end
            end
            LEN_RD: begin
                ct_addr  = 8'd0;
                state_nx = LEN_WR;
            end
            LEN_WR: begin
                pt_addr   = 8'd0;
                pt_wrdata = bus.ct_rddata;
                pt_wren   = 1'b1;
                state_nx  = (bus.ct_rddata == 8'd0) ? IDLE : KS_RI;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath registers: indices, swap holding registers, counters and the latched key
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_reg  <= '0;
            i        <= 8'd0;
            j        <= 8'd0;
            si       <= 8'd0;
            sj       <= 8'd0;
            len      <= 8'd0;
            k        <= 9'd0;
            kidx     <= '0;
            drop_cnt <= 10'd0;
            prga     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.en) begin
                        key_reg  <= bus.key;
                        i        <= 8'd0;
                        j        <= 8'd0;
                        k        <= 9'd0;
                        kidx     <= '0;
                        drop_cnt <= 10'd0;
                        prga     <= 1'b0;
                    end
                end
                INIT: i <= i + 8'd1;
                KSA_WI: begin
                    si <= bus.s_rddata;
                    j  <= j + bus.s_rddata + key_byte;
                end
                KSA_SJ: begin
                    i    <= i + 8'd1;
                    kidx <= (kidx == KW'(KEY_BYTES - 1)) ? '0 : kidx + 1'b1;
                    // i wraps to 0 on its own; j restarts for the keystream
                    if (last_i) j <= 8'd0;
                end
                KS_RI: i <= i + 8'd1;
                KS_WI: begin
                    si <= bus.s_rddata;
                    j  <= j + bus.s_rddata;
                end
                KS_WJ: sj <= bus.s_rddata;
                KS_KS: begin
                    if (prga) k        <= k + 9'd1;
                    else      drop_cnt <= drop_cnt + 10'd1;
                end
                LEN_WR: begin
                    len  <= bus.ct_rddata;
                    k    <= 9'd1;
                    prga <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.rdy       = rdy;
    assign bus.s_addr    = s_addr;
    assign bus.s_wrdata  = s_wrdata;
    assign bus.s_wren    = s_wren;
    assign bus.ct_addr   = ct_addr;
    assign bus.pt_addr   = pt_addr;
    assign bus.pt_wrdata = pt_wrdata;
    assign bus.pt_wren   = pt_wren;
endmodule

// File: tb/tb_arc4_gen.sv
// tb/tb_arc4_gen.sv - directed self-checking bench for arc4_gen
`timescale 1ns/1ps
module tb_arc4_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    arc4_gen_if #(.KEY_BYTES(3)) b0();
    arc4_gen_if #(.KEY_BYTES(5)) b1();
    arc4_gen_if #(.KEY_BYTES(5)) b2();

    arc4_gen #(.KEY_BYTES(3), .DROP_N(0)) u_k3  (.clk(clk), .rst_n(rst_n), .bus(b0));
    arc4_gen #(.KEY_BYTES(5), .DROP_N(0)) u_k5  (.clk(clk), .rst_n(rst_n), .bus(b1));
    arc4_gen #(.KEY_BYTES(5), .DROP_N(8)) u_k5d (.clk(clk), .rst_n(rst_n), .bus(b2));

    logic [7:0] ct_mem [256];
    logic [7:0] s_mem  [256];
    logic [7:0] pt_mem [256];
    logic [7:0] ref_key [32];
    int         ref_ks [256];

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int wr_count = 0;
    int order_err = 0;
    int last_wr_addr = -1;
    int last_wr_cyc = 0;
    int sel = 0;
    logic mon_clr = 1'b0;

    logic       cur_rdy, cur_swren, cur_ptwren, wr_en;
    logic [7:0] cur_saddr, wr_addr, wr_data;

    logic [7:0] exp1 [10] = '{8'h09, 8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    logic [7:0] ct1  [10] = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    logic [7:0] exp2 [8]  = '{8'hB2, 8'h39, 8'h63, 8'h05, 8'hF0, 8'h3D, 8'hC0, 8'h27};
    logic [7:0] exp3 [8]  = '{8'hCC, 8'hC3, 8'h52, 8'h4A, 8'h0A, 8'h11, 8'h18, 8'hA8};

    always_comb begin
        case (sel)
            1:       begin cur_rdy = b1.rdy; cur_swren = b1.s_wren; cur_ptwren = b1.pt_wren; cur_saddr = b1.s_addr; end
            2:       begin cur_rdy = b2.rdy; cur_swren = b2.s_wren; cur_ptwren = b2.pt_wren; cur_saddr = b2.s_addr; end
            default: begin cur_rdy = b0.rdy; cur_swren = b0.s_wren; cur_ptwren = b0.pt_wren; cur_saddr = b0.s_addr; end
        endcase
        wr_en   = b0.pt_wren | b1.pt_wren | b2.pt_wren;
        wr_addr = b0.pt_wren ? b0.pt_addr   : b1.pt_wren ? b1.pt_addr   : b2.pt_addr;
        wr_data = b0.pt_wren ? b0.pt_wrdata : b1.pt_wren ? b1.pt_wrdata : b2.pt_wrdata;
    end

    // Synchronous memories, one-cycle read latency
    always @(posedge clk) begin
        b0.ct_rddata <= ct_mem[b0.ct_addr];
        b1.ct_rddata <= ct_mem[b1.ct_addr];
        b2.ct_rddata <= ct_mem[b2.ct_addr];
        b0.s_rddata  <= s_mem[b0.s_addr];
        b1.s_rddata  <= s_mem[b1.s_addr];
        b2.s_rddata  <= s_mem[b2.s_addr];
        b0.pt_rddata <= pt_mem[b0.pt_addr];
        b1.pt_rddata <= pt_mem[b1.pt_addr];
        b2.pt_rddata <= pt_mem[b2.pt_addr];
        if (b0.s_wren) s_mem[b0.s_addr] <= b0.s_wrdata;
        if (b1.s_wren) s_mem[b1.s_addr] <= b1.s_wrdata;
        if (b2.s_wren) s_mem[b2.s_addr] <= b2.s_wrdata;
    end

    // Plaintext writes: store, count, and track address ordering
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mon_clr) begin
            wr_count     <= 0;
            order_err    <= 0;
            last_wr_addr <= -1;
            last_wr_cyc  <= 0;
            for (int a = 0; a < 256; a++) pt_mem[a] <= 8'hEE;
        end else if (wr_en) begin
            pt_mem[wr_addr] <= wr_data;
            wr_count        <= wr_count + 1;
            if (int'(wr_addr) != last_wr_addr + 1) order_err <= order_err + 1;
            last_wr_addr    <= int'(wr_addr);
            last_wr_cyc     <= cyc;
        end
    end

    task automatic ref_rc4(input int klen, input int drop, input int len);
        int s [256];
        int ii, jj, t;
        for (int a = 0; a < 256; a++) s[a] = a;
        jj = 0;
        for (int a = 0; a < 256; a++) begin
            jj = (jj + s[a] + int'(ref_key[a % klen])) % 256;
            t = s[a]; s[a] = s[jj]; s[jj] = t;
        end
        ii = 0; jj = 0;
        for (int n = 0; n < drop + len; n++) begin
            ii = (ii + 1) % 256;
            jj = (jj + s[ii]) % 256;
            t = s[ii]; s[ii] = s[jj]; s[jj] = t;
            if (n >= drop) ref_ks[n - drop] = s[(s[ii] + s[jj]) % 256];
        end
    endtask

    task automatic clear_mon();
        @(negedge clk); mon_clr = 1'b1;
        @(negedge clk); mon_clr = 1'b0;
    endtask

    task automatic drive_en(input int s, input logic [39:0] kv, input logic v);
        case (s)
            1:       begin b1.key = kv;        b1.en = v; end
            2:       begin b2.key = kv;        b2.en = v; end
            default: begin b0.key = kv[23:0];  b0.en = v; end
        endcase
    endtask

    task automatic run_job(input int s, input logic [39:0] kv, input bit poke,
                           output bit timed_out, output bit rdy_fell, output int gap);
        sel = s;
        clear_mon();
        drive_en(s, kv, 1'b1);
        @(negedge clk);
        drive_en(s, kv, 1'b0);
        rdy_fell = (cur_rdy == 1'b0);
        timed_out = 1'b1;
        for (int n = 0; n < 6000; n++) begin
            if (cur_rdy) begin timed_out = 1'b0; break; end
            if (poke && n == 100) drive_en(s, 40'hFF_FFFF_FFFF, 1'b1);
            if (poke && n == 101) drive_en(s, 40'hFF_FFFF_FFFF, 1'b0);
            @(negedge clk);
        end
        gap = cyc - last_wr_cyc;
    endtask

    task automatic load_msg1();
        for (int a = 0; a < 256; a++) ct_mem[a] = 8'h00;
        for (int a = 0; a < 10; a++) ct_mem[a] = ct1[a];
    endtask

    task automatic test_reset();
        tests_run++;
        if ({b0.rdy, b1.rdy, b2.rdy} !== 3'b111) begin
            tests_failed++; $display("FAIL reset_rdy: got %b expected 111", {b0.rdy, b1.rdy, b2.rdy});
        end
        tests_run++;
        if ({b0.s_wren, b0.pt_wren, b1.s_wren, b1.pt_wren, b2.s_wren, b2.pt_wren} !== 6'b0) begin
            tests_failed++; $display("FAIL reset_wren: some write strobe is high");
        end
        tests_run++;
        if ({b0.s_addr, b0.pt_addr, b0.ct_addr, b0.s_wrdata, b0.pt_wrdata} !== 40'h0) begin
            tests_failed++; $display("FAIL reset_addr: got %h expected 0",
                                     {b0.s_addr, b0.pt_addr, b0.ct_addr, b0.s_wrdata, b0.pt_wrdata});
        end
    endtask

    task automatic test_key3_msg();
        bit to, fell; int gap;
        load_msg1();
        run_job(0, 40'h4B6579, 1'b0, to, fell, gap);
        tests_run++;
        if (to !== 1'b0) begin tests_failed++; $display("FAIL t1_done: timed out"); end
        tests_run++;
        if (fell !== 1'b1) begin tests_failed++; $display("FAIL t1_rdy_fall: rdy got 1 expected 0"); end
        tests_run++;
        if (wr_count !== 10) begin tests_failed++; $display("FAIL t1_writes: got %0d expected 10", wr_count); end
        tests_run++;
        if (gap !== 1) begin tests_failed++; $display("FAIL t1_rdy_gap: got %0d expected 1", gap); end
        for (int a = 0; a < 10; a++) begin
            tests_run++;
            if (pt_mem[a] !== exp1[a]) begin
                tests_failed++; $display("FAIL t1_pt[%0d]: got %02h expected %02h", a, pt_mem[a], exp1[a]);
            end
        end
    endtask

    task automatic test_key5(input int s, input bit with_drop);
        bit to, fell; int gap;
        for (int a = 0; a < 256; a++) ct_mem[a] = 8'h00;
        ct_mem[0] = 8'd8;
        run_job(s, 40'h0102030405, 1'b0, to, fell, gap);
        tests_run++;
        if (to !== 1'b0 || wr_count !== 9) begin
            tests_failed++; $display("FAIL key5_job drop=%0d: timeout=%0b writes=%0d expected 0/9", with_drop, to, wr_count);
        end
        for (int a = 0; a < 8; a++) begin
            tests_run++;
            if (pt_mem[a+1] !== (with_drop ? exp3[a] : exp2[a])) begin
                tests_failed++; $display("FAIL key5_pt drop=%0d [%0d]: got %02h expected %02h",
                                         with_drop, a + 1, pt_mem[a+1], with_drop ? exp3[a] : exp2[a]);
            end
        end
    endtask

    task automatic test_length_bounds();
        bit to, fell; int gap; int bad;
        for (int a = 0; a < 256; a++) ct_mem[a] = 8'h00;
        run_job(0, 40'h4B6579, 1'b0, to, fell, gap);
        tests_run++;
        if (to !== 1'b0 || wr_count !== 1) begin
            tests_failed++; $display("FAIL l0_writes: timeout=%0b writes=%0d expected 0/1", to, wr_count);
        end
        tests_run++;
        if (pt_mem[0] !== 8'h00) begin tests_failed++; $display("FAIL l0_pt0: got %02h expected 00", pt_mem[0]); end
        tests_run++;
        if (gap !== 1) begin tests_failed++; $display("FAIL l0_rdy_gap: got %0d expected 1", gap); end

        for (int a = 0; a < 256; a++) ct_mem[a] = 8'(a);
        ct_mem[0] = 8'd255;
        ref_key[0] = 8'h4B; ref_key[1] = 8'h65; ref_key[2] = 8'h79;
        ref_rc4(3, 0, 255);
        run_job(0, 40'h4B6579, 1'b0, to, fell, gap);
        tests_run++;
        if (to !== 1'b0 || wr_count !== 256) begin
            tests_failed++; $display("FAIL l255_writes: timeout=%0b writes=%0d expected 0/256", to, wr_count);
        end
        tests_run++;
        if (order_err !== 0 || last_wr_addr !== 255) begin
            tests_failed++; $display("FAIL l255_order: order_err=%0d last=%0d expected 0/255", order_err, last_wr_addr);
        end
        bad = 0;
        for (int a = 1; a < 256; a++) if (pt_mem[a] !== (ct_mem[a] ^ 8'(ref_ks[a-1]))) bad++;
        tests_run++;
        if (bad !== 0) begin tests_failed++; $display("FAIL l255_data: got %0d bad bytes expected 0", bad); end
    endtask

    task automatic test_reset_mid_ksa();
        bit to, fell; int gap;
        load_msg1();
        sel = 0;
        clear_mon();
        drive_en(0, 40'h4B6579, 1'b1);
        @(negedge clk);
        drive_en(0, 40'h4B6579, 1'b0);
        repeat (300) @(negedge clk);
        tests_run++;
        if (cur_rdy !== 1'b0) begin tests_failed++; $display("FAIL mid_busy: rdy got 1 expected 0"); end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({cur_rdy, cur_swren, cur_ptwren} !== 3'b100) begin
            tests_failed++; $display("FAIL mid_reset_now: rdy/swren/ptwren got %b expected 100", {cur_rdy, cur_swren, cur_ptwren});
        end
        tests_run++;
        if (cur_saddr !== 8'h00) begin tests_failed++; $display("FAIL mid_reset_saddr: got %02h expected 00", cur_saddr); end
        repeat (5) @(negedge clk);
        tests_run++;
        if (wr_count !== 0 || cur_swren !== 1'b0) begin
            tests_failed++; $display("FAIL mid_reset_quiet: writes=%0d swren=%b expected 0/0", wr_count, cur_swren);
        end
        rst_n = 1'b1;
        @(negedge clk);
        run_job(0, 40'h4B6579, 1'b1, to, fell, gap);
        tests_run++;
        if (to !== 1'b0 || wr_count !== 10) begin
            tests_failed++; $display("FAIL rerun_job: timeout=%0b writes=%0d expected 0/10", to, wr_count);
        end
        for (int a = 0; a < 10; a++) begin
            tests_run++;
            if (pt_mem[a] !== exp1[a]) begin
                tests_failed++; $display("FAIL rerun_pt[%0d]: got %02h expected %02h", a, pt_mem[a], exp1[a]);
            end
        end
    endtask

    task automatic test_model_msg();
        bit to, fell; int gap; int bad;
        for (int a = 0; a < 256; a++) ct_mem[a] = 8'(a * 37 + 11);
        ct_mem[0] = 8'h18;
        ref_key[0] = 8'h1E; ref_key[1] = 8'h46; ref_key[2] = 8'h00;
        ref_rc4(3, 0, 24);
        run_job(0, 40'h1E4600, 1'b0, to, fell, gap);
        tests_run++;
        if (fell !== 1'b1 || to !== 1'b0) begin
            tests_failed++; $display("FAIL t6_handshake: fell=%0b timeout=%0b expected 1/0", fell, to);
        end
        tests_run++;
        if (wr_count !== 25 || gap !== 1) begin
            tests_failed++; $display("FAIL t6_writes: writes=%0d gap=%0d expected 25/1", wr_count, gap);
        end
        bad = 0;
        for (int a = 1; a <= 24; a++) if (pt_mem[a] !== (ct_mem[a] ^ 8'(ref_ks[a-1]))) bad++;
        if (pt_mem[0] !== 8'h18) bad++;
        tests_run++;
        if (bad !== 0) begin tests_failed++; $display("FAIL t6_data: got %0d bad bytes expected 0", bad); end
    endtask

    initial begin
        b0.en = 1'b0; b1.en = 1'b0; b2.en = 1'b0;
        b0.key = '0;  b1.key = '0;  b2.key = '0;
        for (int a = 0; a < 256; a++) ct_mem[a] = 8'h00;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_key3_msg();
        test_key5(1, 1'b0);
        test_key5(2, 1'b1);
        test_length_bounds();
        test_reset_mid_ksa();
        test_model_msg();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
